// File: rtl/spi_master_seq_if.sv
// spi_master_seq_if: controller request/response signals and SPI pins of spi_master_seq.
interface spi_master_seq_if #(
  parameter int WORD_W = 16
);
  logic              start;
  logic [3:0]        cmd;
  logic [7:0]        pk_sz;
  logic [WORD_W-1:0] wr_data;
  logic              busy;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              err;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  modport master (
    input  start, cmd, pk_sz, wr_data, spi_miso,
    output busy, rd_data, rd_valid, done, err, spi_sclk, spi_cs_n, spi_mosi
  );
  modport slave (
    output start, cmd, pk_sz, wr_data, spi_miso,
    input  busy, rd_data, rd_valid, done, err, spi_sclk, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_master_seq.sv
// spi_master_seq: SPI mode-0 command sequencer framing a 16-bit header plus data words under one CS.
// Optional SPI_WORD_GAP_EN inserts GAP_CYC idle SCLK-low cycles between consecutive FIFO words.
`ifndef RD
`define RD 4'h1
`endif
`ifndef WR
`define WR 4'h2
`endif
`ifndef FIFO
`define FIFO 4'h3
`endif
module spi_master_seq #(
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 8
) (
  input logic              clk,
  input logic              rst,
  spi_master_seq_if.master bus
);
  localparam int TX_W  = 16 + WORD_W;
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_SETUP = 6'b000010,
    S_HDR   = 6'b000100,
    S_DATA  = 6'b001000,
    S_HOLD  = 6'b010000
`ifdef SPI_WORD_GAP_EN
    , S_GAP = 6'b100000
`endif
  } st_t;
  st_t               r_st;
  logic [DIV_W-1:0]  r_div;
  logic [4:0]        r_bit;
  logic [7:0]        r_cnt;
  logic [TX_W-1:0]   r_tx;
  logic [WORD_W-1:0] r_rx;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rdc;
  logic              r_wend;
  logic              r_busy;
  logic              r_rv;
  logic              r_done;
  logic              r_err;
  logic              r_sclk;
  logic              r_cs_n;
`ifdef SPI_WORD_GAP_EN
  localparam int GW = $clog2(GAP_CYC + 1);
  logic [GW-1:0]     r_gap;
`endif
  logic              w_fifo;
  logic              w_ok;
  logic              w_half;
  logic              w_bit_end;
  logic              w_word_end;
  logic [15:0]       w_hdr;
  assign w_fifo     = bus.cmd == `FIFO;
  assign w_ok       = w_fifo || bus.cmd == `RD || bus.cmd == `WR;
  assign w_hdr      = {bus.cmd, 4'h0, w_fifo ? bus.pk_sz : 8'h00};
  assign w_half     = r_div == DIV_W'(CLK_DIV - 1);
  assign w_bit_end  = r_div == DIV_W'(2 * CLK_DIV - 1);
  assign w_word_end = r_bit == 5'(WORD_W - 1);
  // r_tx[TX_W-1] is the bit on the wire; the word counter stops at zero instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= S_IDLE;
      r_div     <= '0;
      r_bit     <= '0;
      r_cnt     <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rd_data <= '0;
      r_rdc     <= 1'b0;
      r_wend    <= 1'b0;
      r_busy    <= 1'b0;
      r_rv      <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
`ifdef SPI_WORD_GAP_EN
      r_gap     <= '0;
`endif
    end else begin
      r_rv   <= r_wend;
      r_wend <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_wend) r_rd_data <= r_rx;
      unique case (r_st)
        S_IDLE: if (bus.start) begin
          if (w_ok) begin
            r_st   <= S_SETUP;
            r_busy <= 1'b1;
            r_cs_n <= 1'b0;
            r_div  <= '0;
            r_tx   <= {w_hdr, bus.cmd == `WR ? bus.wr_data : {WORD_W{1'b0}}};
            r_cnt  <= w_fifo ? bus.pk_sz : 8'h00;
            r_rdc  <= bus.cmd != `WR;
          end else begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end
        end
        S_SETUP: begin
          r_div <= w_half ? '0 : r_div + 1'b1;
          if (w_half) begin
            r_st  <= S_HDR;
            r_bit <= '0;
          end
        end
        S_HDR, S_DATA: begin
          r_div <= w_bit_end ? '0 : r_div + 1'b1;
          if (w_half) begin
            r_sclk <= 1'b1;
            r_rx   <= {r_rx[WORD_W-2:0], bus.spi_miso};
            r_wend <= r_st == S_DATA && r_rdc && w_word_end;
          end
          if (w_bit_end) begin
            r_sclk <= 1'b0;
            r_tx   <= r_tx << 1;
            r_bit  <= r_bit + 1'b1;
            if (r_st == S_HDR && r_bit == 5'd15) begin
              r_st  <= S_DATA;
              r_bit <= '0;
            end else if (r_st == S_DATA && w_word_end) begin
              r_bit <= '0;
              if (r_cnt == 8'h00) r_st <= S_HOLD;
              else begin
                r_cnt <= r_cnt - 8'd1;
`ifdef SPI_WORD_GAP_EN
                r_st  <= S_GAP;
                r_gap <= '0;
`endif
              end
            end
          end
        end
`ifdef SPI_WORD_GAP_EN
        S_GAP: begin
          r_gap <= r_gap + 1'b1;
          if (r_gap == GW'(GAP_CYC - 1)) r_st <= S_DATA;
        end
`endif
        S_HOLD: begin
          r_div <= r_div + 1'b1;
          if (w_half) begin
            r_st   <= S_IDLE;
            r_div  <= '0;
            r_busy <= 1'b0;
            r_cs_n <= 1'b1;
            r_done <= 1'b1;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end
  assign bus.busy     = r_busy;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rv;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.spi_sclk = r_sclk;
  assign bus.spi_cs_n = r_cs_n;
  assign bus.spi_mosi = r_tx[TX_W-1];
endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: per-cycle timeline model of spi_master_seq plus literal spot checks.
`ifndef RD
`define RD 4'h1
`endif
`ifndef WR
`define WR 4'h2
`endif
`ifndef FIFO
`define FIFO 4'h3
`endif
module tb_spi_master_seq;
  localparam int W = 16;
  localparam int D = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_master_seq_if #(.WORD_W(W)) bus ();
  spi_master_seq #(.WORD_W(W), .CLK_DIV(D), .GAP_CYC(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_err = 0;
  int cur_t;
  logic [3:0]  m_cmd;
  logic [15:0] m_wd;
  logic [15:0] m_hdr;
  bit m_bad, m_rdc;
  int m_nw, m_nbits, m_L;
  int cs_low, cs_fall, rv_cnt, dn_cnt, er_cnt, cap_n;
  logic [31:0] cap32;
  logic [15:0] first_rd, last_rd;
  logic prev_cs, prev_sclk;
  logic [15:0] sl_words [0:255];
  int sl_nw = 0;
  int sl_bit = 0;
  int sl_d;
  logic sl_prev = 1'b0;
  // slave: header bits are don't-care (0), then data words MSB first, advancing after each SCLK fall
  always @(posedge clk) begin
    if (bus.spi_cs_n) sl_bit <= 0;
    else if (sl_prev && !bus.spi_sclk) sl_bit <= sl_bit + 1;
    sl_prev <= bus.spi_sclk;
  end
  assign sl_d = sl_bit - 16;
  assign bus.spi_miso = (sl_d >= 0 && sl_d < sl_nw * 16) ? sl_words[sl_d / 16][15 - sl_d % 16] : 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 25) $display("FAIL %s t=%0d act=%h exp=%h", nm, cur_t, act, exp);
    end
  endtask
  // expected outputs t cycles after the accepting edge, derived from the bit-timeline arithmetic
  task automatic check_cycle(input int t);
    int q, b, r;
    logic busy_e, sclk_e, mosi_e, rv_e;
    busy_e = !m_bad && t < m_L;
    q = t - D;
    b = (q < 0) ? 0 : q / (2 * D);
    sclk_e = busy_e && q >= 0 && b < m_nbits && (q % (2 * D)) >= D;
    mosi_e = 1'b0;
    if (busy_e && b < m_nbits) mosi_e = (b < 16) ? m_hdr[15 - b] : (m_cmd == `WR ? m_wd[31 - b] : 1'b0);
    r = t - (2 * D + 1) - (16 + W - 1) * 2 * D;
    rv_e = !m_bad && m_rdc && r >= 0 && r % (W * 2 * D) == 0 && r / (W * 2 * D) < m_nw;
    cur_t = t;
    chk("busy", 32'(bus.busy), 32'(busy_e));
    chk("cs_n", 32'(bus.spi_cs_n), 32'(!busy_e));
    chk("sclk", 32'(bus.spi_sclk), 32'(sclk_e));
    chk("mosi", 32'(bus.spi_mosi), 32'(mosi_e));
    chk("rd_valid", 32'(bus.rd_valid), 32'(rv_e));
    chk("done", 32'(bus.done), 32'(t == m_L));
    chk("err", 32'(bus.err), 32'(m_bad && t == m_L));
    if (rv_e) chk("rd_data", 32'(bus.rd_data), 32'(sl_words[r / (W * 2 * D)]));
  endtask
  task automatic txn(input logic [3:0] c, input logic [7:0] pk, input logic [15:0] wd,
                     input int rst_at, input bit poke);
    m_cmd   = c;
    m_wd    = wd;
    m_bad   = !(c == `RD || c == `WR || c == `FIFO);
    m_rdc   = c != `WR;
    m_nw    = (c == `FIFO) ? int'(pk) + 1 : 1;
    m_nbits = 16 + m_nw * W;
    m_L     = m_bad ? 0 : 2 * D + m_nbits * 2 * D;
    m_hdr   = {c, 4'h0, (c == `FIFO) ? pk : 8'h00};
    sl_nw   = m_nw;
    cs_low = 0; cs_fall = 0; rv_cnt = 0; dn_cnt = 0; er_cnt = 0; cap_n = 0;
    cap32 = '0; first_rd = '0; last_rd = '0;
    prev_cs = 1'b1; prev_sclk = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd = c; bus.pk_sz = pk; bus.wr_data = wd;
    for (int t = 0; t <= m_L + 2; t++) begin
      @(negedge clk);
      check_cycle(t);
      if (!bus.spi_cs_n) cs_low++;
      if (prev_cs && !bus.spi_cs_n) cs_fall++;
      if (bus.spi_sclk && !prev_sclk && cap_n < 32) begin
        cap32 = {cap32[30:0], bus.spi_mosi};
        cap_n++;
      end
      if (bus.rd_valid) begin
        if (rv_cnt == 0) first_rd = bus.rd_data;
        last_rd = bus.rd_data;
        rv_cnt++;
      end
      if (bus.done) dn_cnt++;
      if (bus.err) er_cnt++;
      prev_cs = bus.spi_cs_n;
      prev_sclk = bus.spi_sclk;
      bus.start = poke && t == 20;
      if (poke && t == 20) begin
        bus.cmd = `FIFO; bus.pk_sz = 8'hFF; bus.wr_data = 16'hFFFF;
      end
      if (t == rst_at) begin
        rst = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0; bus.cmd = '0; bus.pk_sz = '0; bus.wr_data = '0;
    for (int i = 0; i < 256; i++) sl_words[i] = '0;
    repeat (3) @(negedge clk);
    cur_t = -1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_sclk", 32'(bus.spi_sclk), 32'd0);
    chk("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
    chk("rst_mosi", 32'(bus.spi_mosi), 32'd0);
    rst = 1'b0;
    txn(`WR, 8'h00, 16'hA5C3, -1, 1'b1);
    chk("wr_cs_low", 32'(cs_low), 32'd132);
    chk("wr_cs_falls", 32'(cs_fall), 32'd1);
    chk("wr_mosi", cap32, 32'h2000_A5C3);
    chk("wr_done_cnt", 32'(dn_cnt), 32'd1);
    chk("wr_rv_cnt", 32'(rv_cnt), 32'd0);
    sl_words[0] = 16'h1234;
    txn(`RD, 8'h00, 16'h0000, -1, 1'b0);
    chk("rd_rv_cnt", 32'(rv_cnt), 32'd1);
    chk("rd_data", 32'(last_rd), 32'h1234);
    chk("rd_hdr", cap32, 32'h1000_0000);
    chk("rd_err_cnt", 32'(er_cnt), 32'd0);
    chk("rd_done_cnt", 32'(dn_cnt), 32'd1);
    for (int i = 0; i < 4; i++) sl_words[i] = 16'(i + 1);
    txn(`FIFO, 8'd3, 16'h0000, -1, 1'b0);
    chk("f3_rv_cnt", 32'(rv_cnt), 32'd4);
    chk("f3_first", 32'(first_rd), 32'h0001);
    chk("f3_last", 32'(last_rd), 32'h0004);
    chk("f3_hdr_lo", 32'(cap32[23:16]), 32'h03);
    chk("f3_cs_falls", 32'(cs_fall), 32'd1);
    chk("f3_done_cnt", 32'(dn_cnt), 32'd1);
    sl_words[0] = 16'hBEEF;
    txn(`FIFO, 8'd0, 16'h0000, -1, 1'b0);
    chk("f0_rv_cnt", 32'(rv_cnt), 32'd1);
    chk("f0_data", 32'(last_rd), 32'hBEEF);
    for (int i = 0; i < 256; i++) sl_words[i] = 16'(i * 257) ^ 16'h5A5A;
    txn(`FIFO, 8'd255, 16'h0000, -1, 1'b0);
    chk("f255_rv_cnt", 32'(rv_cnt), 32'd256);
    chk("f255_last", 32'(last_rd), 32'hA5A5);
    chk("f255_cs_low", 32'(cs_low), 32'd16452);
    txn(4'hF, 8'h00, 16'h0000, -1, 1'b0);
    chk("bad_cs_falls", 32'(cs_fall), 32'd0);
    chk("bad_done_cnt", 32'(dn_cnt), 32'd1);
    chk("bad_err_cnt", 32'(er_cnt), 32'd1);
    for (int i = 0; i < 4; i++) sl_words[i] = 16'(i + 1);
    txn(`FIFO, 8'd3, 16'h0000, 4 + 37 * 4, 1'b0);
    @(negedge clk);
    cur_t = -2;
    chk("abort_cs_n", 32'(bus.spi_cs_n), 32'd1);
    chk("abort_sclk", 32'(bus.spi_sclk), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("abort_rd_data", 32'(bus.rd_data), 32'd0);
    chk("abort_rv_cnt", 32'(rv_cnt), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    sl_words[0] = 16'hC0DE;
    txn(`RD, 8'h00, 16'h0000, -1, 1'b0);
    chk("post_rv_cnt", 32'(rv_cnt), 32'd1);
    chk("post_data", 32'(last_rd), 32'hC0DE);
    chk("post_done_cnt", 32'(dn_cnt), 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
